pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Consumer-side companion to the iCE40 PLL wrappers. It takes the PLL `locked` flag, which is asynchronous to the PLL output clock, and synchronizes and qualifies it. It then releases a clean, synchronous, active-low reset to the logic running on the PLL output clock. Lock-loss events are counted and flagged for status readout. One instance sits directly behind each PLL, clocked by that PLL's output.

## Interface
Parameters:
- `STABLE_CYCLES`, default 1024: consecutive synchronized-locked cycles required before reset release; legal range ≥ 1.
- `HOLDOFF_CYCLES`, default 256: minimum cycles reset is held after a lock loss; legal range ≥ 1.
- `CNT_WIDTH`, default 8: width of the lock-loss counter.

Ports:
- `clock_in`  in  1  PLL output clock; the only clock.
- `reset_n`  in  1  synchronous, active-low reset.
- `locked_in`  in  1  PLL lock flag, asynchronous.
- `clear_count`  in  1  single-cycle pulse; clears `loss_count` and `loss_sticky`.
- `rst_out_n`  out  1  synchronous active-low reset for downstream logic.
- `ready`  out  1  high while downstream is released (state RUN).
- `loss_count`  out  CNT_WIDTH  number of RUN→loss events, saturating.
- `loss_sticky`  out  1  set on any loss event; cleared only by `clear_count` or reset.

## Operation
- `locked_in` passes through a 2-flop synchronizer to produce `locked_s`. Nothing else samples `locked_in`.
- One timer, width `$clog2(max(STABLE_CYCLES, HOLDOFF_CYCLES))`, minimum 1 bit. It is cleared on every state entry.
- The FSM has four states:
  - WAIT_LOCK (reset state): `rst_out_n`=0, `ready`=0. If `locked_s`=1, go to STABILIZE.
  - STABILIZE: the timer increments each cycle. If `locked_s`=0, return to WAIT_LOCK with no count and no sticky. If timer == STABLE_CYCLES-1 and `locked_s`=1, go to RUN.
  - RUN: `rst_out_n`=1, `ready`=1. If `locked_s`=0, go to HOLDOFF; `loss_count` increments (saturating at all ones) and `loss_sticky` is set.
  - HOLDOFF: `rst_out_n`=0. The timer runs regardless of `locked_s`. At timer == HOLDOFF_CYCLES-1, go to WAIT_LOCK.
- `rst_out_n` and `ready` are flops, high exactly when the state register holds RUN. There is no combinational path from any input.
- `clear_count` zeroes `loss_count` and `loss_sticky`. If it coincides with a loss event, the loss wins: `loss_count`=1, `loss_sticky`=1.
- When `reset_n`=0 at an edge, the next state is:
  - FSM = WAIT_LOCK, synchronizer = 0, timer = 0.
  - `rst_out_n`=0, `ready`=0, `loss_count`=0, `loss_sticky`=0.
  - This applies mid-RUN too: `rst_out_n` falls after that edge, and no loss is counted.

## Timing
- Reset values of all outputs are 0.
- Lock-acquire latency, with `locked_in` high and stable before edge 0:
  - `locked_s` is high after edge 1.
  - The FSM enters STABILIZE after edge 2.
  - `rst_out_n`/`ready` rise after edge 2+STABLE_CYCLES.
- Loss latency, with `locked_in` low before edge j:
  - The FSM enters HOLDOFF after edge j+2.
  - `rst_out_n` falls after edge j+2.
  - `loss_count` updates at the same edge.
- Minimum reset-low time after a loss:
  - HOLDOFF_CYCLES + 1 (WAIT_LOCK) + STABLE_CYCLES cycles.
  - A `locked_in` glitch shorter than 1 cycle may be missed; this is by design.
- Relock during HOLDOFF is ignored until HOLDOFF completes. WAIT_LOCK then exits on the next edge if `locked_s`=1.

## Structure
- Shared package `pll_supervisor_pkg` holds:
  - the state encoding localparams (WAIT_LOCK=2'd0, STABILIZE=2'd1, RUN=2'd2, HOLDOFF=2'd3);
  - the default STABLE/HOLDOFF constants, reused by every PLL instance in the tops.
- One sub-module, `sync_2ff`: generic 2-flop synchronizer with synchronous active-low reset to 0. It is reused for other async inputs.
- The FSM, timer and loss counter are in the top module.

## Test plan
Bench parameters: STABLE_CYCLES=8, HOLDOFF_CYCLES=4, CNT_WIDTH=2.
- Acquire: reset, then `locked_in`=1 before edge 0 → `rst_out_n`/`ready` rise after edge 10; `loss_count`=0.
- Unstable lock: `locked_in` high for 5 cycles, then low, then high → no release until 8 full stable cycles after the final rise; `loss_sticky` stays 0.
- Loss in RUN: drop `locked_in` before edge j → `rst_out_n` falls after edge j+2, `loss_count`=1, `loss_sticky`=1. Relock immediately → release no earlier than 4+1+8 cycles later.
- Saturation/clear: 5 loss events → `loss_count`=3. Pulse `clear_count` on the same edge as a 6th loss → `loss_count`=1, `loss_sticky`=1.
- Reset mid-RUN: `reset_n`=0 for one edge while in RUN → all outputs 0 after that edge, no count. With `locked_in` still high, release 10 edges after `reset_n` returns high.

Source files
------------

// File: rtl/pll_supervisor_pkg.sv
// Shared definitions for PLL lock supervision: state encoding, default
// qualification/holdoff lengths and timer sizing.
package pll_supervisor_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      STABILIZE = 2'd1,
      RUN       = 2'd2,
      HOLDOFF   = 2'd3
   } sup_state_e;

   localparam int unsigned DEFAULT_STABLE_CYCLES  = 1024;
   localparam int unsigned DEFAULT_HOLDOFF_CYCLES = 256;

   // Timer must hold max(a,b)-1; never narrower than one bit.
   function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
      int unsigned m;
      m = (a > b) ? a : b;
      return (m <= 2) ? 1 : $clog2(m);
   endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous level inputs; synchronous
// active-low reset clears both stages to 0.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clock_in,
   input  logic             reset_n,
   input  logic [WIDTH-1:0] async_in,
   output logic [WIDTH-1:0] sync_out
);

   logic [WIDTH-1:0] meta;

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         meta     <= '0;
         sync_out <= '0;
      end else begin
         meta     <= async_in;
         sync_out <= meta;
      end
   end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Qualifies the PLL locked flag and releases a clean synchronous reset to
// logic on the PLL output clock; counts and flags lock-loss events.
//
// state     | meaning
// ----------+------------------------------------------------------------
// WAIT_LOCK | downstream held in reset, waiting for synchronized lock
// STABILIZE | lock seen, counting consecutive locked cycles
// RUN       | downstream released; a lock drop is a counted loss event
// HOLDOFF   | forced minimum reset time after a loss, lock ignored
module pll_lock_supervisor
   import pll_supervisor_pkg::*;
#(
   parameter int unsigned STABLE_CYCLES  = DEFAULT_STABLE_CYCLES,
   parameter int unsigned HOLDOFF_CYCLES = DEFAULT_HOLDOFF_CYCLES,
   parameter int unsigned CNT_WIDTH      = 8
) (
   input  logic                 clock_in,
   input  logic                 reset_n,
   input  logic                 locked_in,
   input  logic                 clear_count,
   output logic                 rst_out_n,
   output logic                 ready,
   output logic [CNT_WIDTH-1:0] loss_count,
   output logic                 loss_sticky
);

   localparam int unsigned TW = timer_width(STABLE_CYCLES, HOLDOFF_CYCLES);
   localparam logic [TW-1:0] STABLE_LAST  = TW'(STABLE_CYCLES - 1);
   localparam logic [TW-1:0] HOLDOFF_LAST = TW'(HOLDOFF_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

   sup_state_e           state, state_nx;
   logic [TW-1:0]        timer, timer_nx;
   logic [CNT_WIDTH-1:0] count_nx;
   logic                 sticky_nx;
   logic                 locked_s;
   logic                 loss_event;

   sync_2ff #(
      .WIDTH (1)
   ) u_lock_sync (
      .clock_in (clock_in),
      .reset_n  (reset_n),
      .async_in (locked_in),
      .sync_out (locked_s)
   );

   always_comb begin
      state_nx   = state;
      loss_event = 1'b0;
      case (state)
         WAIT_LOCK: begin
            if (locked_s) state_nx = STABILIZE;
         end
         STABILIZE: begin
            if (!locked_s)                 state_nx = WAIT_LOCK;
            else if (timer == STABLE_LAST) state_nx = RUN;
         end
         RUN: begin
            if (!locked_s) begin
               state_nx   = HOLDOFF;
               loss_event = 1'b1;
            end
         end
         HOLDOFF: begin
            if (timer == HOLDOFF_LAST) state_nx = WAIT_LOCK;
         end
         default: state_nx = WAIT_LOCK;
      endcase
   end

   // Timer restarts from zero on every state change.
   always_comb begin
      timer_nx = '0;
      if (state_nx == state && (state == STABILIZE || state == HOLDOFF))
         timer_nx = timer + 1'b1;
   end

   // A loss on the same edge as a clear still registers as one fresh loss.
   always_comb begin
      count_nx  = loss_count;
      sticky_nx = loss_sticky;
      if (loss_event) begin
         sticky_nx = 1'b1;
         if (clear_count)     count_nx = CNT_ONE;
         else if (!(&loss_count)) count_nx = loss_count + 1'b1;
      end else if (clear_count) begin
         count_nx  = '0;
         sticky_nx = 1'b0;
      end
   end

   always_ff @(posedge clock_in) begin
      if (!reset_n) begin
         state       <= WAIT_LOCK;
         timer       <= '0;
         rst_out_n   <= 1'b0;
         ready       <= 1'b0;
         loss_count  <= '0;
         loss_sticky <= 1'b0;
      end else begin
         state       <= state_nx;
         timer       <= timer_nx;
         rst_out_n   <= (state_nx == RUN);
         ready       <= (state_nx == RUN);
         loss_count  <= count_nx;
         loss_sticky <= sticky_nx;
      end
   end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor: expected output transitions are
// queued with their edge number; a monitor checks every observed change.
module tb_pll_lock_supervisor;

   localparam int unsigned S = 8;
   localparam int unsigned H = 4;
   localparam int unsigned W = 2;

   logic         clock_in = 1'b0;
   logic         reset_n;
   logic         locked_in;
   logic         clear_count;
   logic         rst_out_n;
   logic         ready;
   logic [W-1:0] loss_count;
   logic         loss_sticky;

   typedef struct {
      int       cyc;
      int       id;
      logic [4:0] v;
   } exp_t;

   exp_t exp_q[$];
   int   cyc       = 0;
   int   tests_run = 0;
   int   fails     = 0;
   int   next_id   = 0;
   bit   mon_en    = 1'b0;
   logic [4:0] prev_v;
   logic [4:0] cur_v;
   exp_t       e;

   pll_lock_supervisor #(
      .STABLE_CYCLES  (S),
      .HOLDOFF_CYCLES (H),
      .CNT_WIDTH      (W)
   ) dut (
      .clock_in    (clock_in),
      .reset_n     (reset_n),
      .locked_in   (locked_in),
      .clear_count (clear_count),
      .rst_out_n   (rst_out_n),
      .ready       (ready),
      .loss_count  (loss_count),
      .loss_sticky (loss_sticky)
   );

   always #5 clock_in = ~clock_in;

   always @(posedge clock_in) cyc <= cyc + 1;

   // Monitor: every change of the output vector must match the queue head.
   always @(negedge clock_in) begin
      if (mon_en) begin
         cur_v = {rst_out_n, ready, loss_count, loss_sticky};
         if (cur_v !== prev_v) begin
            tests_run++;
            if (exp_q.size() == 0) begin
               fails++;
               $display("FAIL unexpected_change: outputs {rst,ready,cnt,sticky}=%b at edge %0d, none expected",
                        cur_v, cyc);
            end else begin
               e = exp_q.pop_front();
               if (e.cyc != cyc || e.v !== cur_v)
                  begin
                     fails++;
                     $display("FAIL transition_%0d: got %b at edge %0d, required %b at edge %0d",
                              e.id, cur_v, cyc, e.v, e.cyc);
                  end
            end
            prev_v = cur_v;
         end
      end
   end

   task automatic push(input int c, input logic r, input logic rd,
                       input logic [W-1:0] cnt, input logic st);
      exp_t x;
      x.cyc = c;
      x.id  = next_id;
      x.v   = {r, rd, cnt, st};
      next_id++;
      exp_q.push_back(x);
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clock_in);
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step(1);
   endtask

   task automatic check1(input string name, input logic got, input logic req);
      tests_run++;
      if (got !== req) begin
         fails++;
         $display("FAIL %s: got %b, required %b", name, got, req);
      end
   endtask

   // One-cycle lock drop from RUN with immediate relock; optional clear on
   // the loss edge itself.
   task automatic loss_relock(input logic [W-1:0] cnt, input bit with_clear);
      int c;
      c = cyc;
      locked_in = 1'b0;
      push(c + 3, 1'b0, 1'b0, cnt, 1'b1);
      step(1);
      locked_in = 1'b1;
      push(c + 3 + H + 1 + S, 1'b1, 1'b1, cnt, 1'b1);
      if (with_clear) begin
         step(1);
         clear_count = 1'b1;
         step(1);
         clear_count = 1'b0;
      end
      wait_until(c + 18);
   endtask

   initial begin
      int c;
      reset_n     = 1'b0;
      locked_in   = 1'b0;
      clear_count = 1'b0;
      step(3);
      check1("reset_rst_out_n", rst_out_n, 1'b0);
      check1("reset_ready", ready, 1'b0);
      check1("reset_loss_count_zero", (loss_count == '0), 1'b1);
      check1("reset_loss_sticky", loss_sticky, 1'b0);
      prev_v = 5'b0;
      mon_en = 1'b1;
      reset_n = 1'b1;

      // Acquire: lock before edge 0 -> release after edge 10.
      c = cyc;
      locked_in = 1'b1;
      push(c + 11, 1'b1, 1'b1, 2'd0, 1'b0);
      wait_until(c + 13);

      // Losses 1..5 (saturating at 3), then a 6th coinciding with clear.
      loss_relock(2'd1, 1'b0);
      loss_relock(2'd2, 1'b0);
      loss_relock(2'd3, 1'b0);
      loss_relock(2'd3, 1'b0);
      loss_relock(2'd3, 1'b0);
      loss_relock(2'd1, 1'b1);

      // Reset mid-RUN with lock held.
      c = cyc;
      reset_n = 1'b0;
      push(c + 1, 1'b0, 1'b0, 2'd0, 1'b0);
      step(1);
      reset_n = 1'b1;
      push(c + 12, 1'b1, 1'b1, 2'd0, 1'b0);
      wait_until(c + 14);

      // Reset with lock removed, then an unstable lock.
      c = cyc;
      reset_n   = 1'b0;
      locked_in = 1'b0;
      push(c + 1, 1'b0, 1'b0, 2'd0, 1'b0);
      step(1);
      reset_n = 1'b1;
      step(4);
      c = cyc;
      locked_in = 1'b1;
      step(5);
      locked_in = 1'b0;
      step(2);
      locked_in = 1'b1;
      push(c + 18, 1'b1, 1'b1, 2'd0, 1'b0);
      wait_until(c + 22);
      check1("unstable_sticky_clear", loss_sticky, 1'b0);
      check1("unstable_ready_final", ready, 1'b1);

      tests_run++;
      if (exp_q.size() != 0) begin
         fails++;
         $display("FAIL pending_transitions: %0d expected changes never seen, required 0", exp_q.size());
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule
